// File: rtl/cpu_control_fsm.sv
// Multi-cycle main control unit: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the datapath enables, ALUOp and the memory request/handshake.
module cpu_control_fsm #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_NOOP, C_JUMP, C_BRANCH, C_RTYPE, C_IMM, C_LOAD, C_STORE, C_ILLEGAL
    } op_class_t;

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    state_t           state_reg, state_next;
    logic [5:0]       op_reg, op_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             timeout;
    op_class_t        dec_class, exe_class;

    // LI/LUI share the immediate datapath; LWI/SWI share the load/store path.
    function automatic op_class_t op_class(input logic [5:0] op);
        casez (op)
            6'b000000:             op_class = C_NOOP;
            6'b000001:             op_class = C_JUMP;
            6'b01????:             op_class = C_RTYPE;
            6'b1000??:             op_class = C_BRANCH;
            6'b11001?, 6'b1101??:  op_class = C_IMM;
            6'b111001, 6'b111010:  op_class = C_IMM;
            6'b111011, 6'b111101:  op_class = C_LOAD;
            6'b111100, 6'b111110:  op_class = C_STORE;
            default:               op_class = C_ILLEGAL;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= FETCH;
            op_reg       <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    assign timeout   = (wait_cnt_reg == WAIT_LIM) && !mem_ready;
    assign dec_class = op_class(opcode);
    assign exe_class = op_class(op_reg);
    assign state_dbg = state_reg;

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        wait_cnt_next = wait_cnt_reg;
        ALUOp         = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'd0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_op    = 1'b0;
        bus_err       = 1'b0;

        // Outputs must read as zero for the whole time reset is held, not just after the edge.
        if (!rst) begin
            case (state_reg)
                FETCH: begin
                    alu_src_b = 2'd1;
                    if (timeout) begin
                        bus_err       = 1'b1;
                        wait_cnt_next = '0;
                    end else begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            ir_write      = 1'b1;
                            pc_write      = 1'b1;
                            state_next    = DECODE;
                            wait_cnt_next = '0;
                        end else begin
                            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                DECODE: begin
                    op_next       = opcode;
                    alu_src_b     = 2'd3;
                    wait_cnt_next = '0;
                    case (dec_class)
                        C_NOOP:    state_next = FETCH;
                        C_ILLEGAL: begin
                            illegal_op = 1'b1;
                            state_next = FETCH;
                        end
                        default:   state_next = EXEC;
                    endcase
                end
                EXEC: begin
                    wait_cnt_next = '0;
                    case (exe_class)
                        C_JUMP: begin
                            pc_write   = 1'b1;
                            pc_source  = 2'd2;
                            state_next = FETCH;
                        end
                        C_BRANCH: begin
                            ALUOp         = 2'd2;
                            alu_src_a     = 1'b1;
                            pc_write_cond = 1'b1;
                            pc_source     = 2'd1;
                            state_next    = FETCH;
                        end
                        C_RTYPE: begin
                            ALUOp      = 2'd2;
                            alu_src_a  = 1'b1;
                            state_next = WB;
                        end
                        C_IMM: begin
                            ALUOp      = 2'd2;
                            alu_src_a  = 1'b1;
                            alu_src_b  = 2'd2;
                            state_next = WB;
                        end
                        C_LOAD, C_STORE: begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = 2'd2;
                            state_next = MEM;
                        end
                        default: state_next = FETCH;
                    endcase
                end
                MEM: begin
                    iord = 1'b1;
                    if (timeout) begin
                        bus_err       = 1'b1;
                        state_next    = FETCH;
                        wait_cnt_next = '0;
                    end else begin
                        mem_read  = (exe_class == C_LOAD);
                        mem_write = (exe_class == C_STORE);
                        if (mem_ready) begin
                            state_next    = (exe_class == C_LOAD) ? WB : FETCH;
                            wait_cnt_next = '0;
                        end else begin
                            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                WB: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = (exe_class == C_LOAD);
                    state_next    = FETCH;
                    wait_cnt_next = '0;
                end
                default: begin
                    state_next    = FETCH;
                    wait_cnt_next = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: a per-instruction expected-cycle trace is built from opcode class
// and memory latencies, then replayed against the DUT cycle by cycle.
module tb_cpu_control_fsm;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       iord, mem_read, mem_write, ir_write, reg_write, mem_to_reg;
    logic       illegal_op, bus_err;
    logic [2:0] state_dbg;

    cpu_control_fsm #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
        .bus_err(bus_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rw;
        logic       m2r;
        logic       ill;
        logic       berr;
        logic [2:0] st;
    } out_t;

    typedef struct packed {
        logic        mr;
        logic [19:0] exp;
        logic [19:0] mask;
    } cyc_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        int         fw;
        int         mw;
        int         cycles;
        int         rw_n;
        int         mwr_n;
        int         ill_n;
        int         berr_n;
    } vec_t;

    out_t  act;
    cyc_t  plan[$];
    int    total = 0;
    int    bad   = 0;
    int    rw_seen, mwr_seen, ill_seen, berr_seen;

    assign act = {ALUOp, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source, iord,
                  mem_read, mem_write, ir_write, reg_write, mem_to_reg, illegal_op, bus_err,
                  state_dbg};

    // Instruction classes from opcode value ranges.
    localparam int K_NOOP = 0, K_JUMP = 1, K_BR = 2, K_R = 3, K_IMM = 4, K_LD = 5, K_ST = 6,
                   K_ILL = 7;

    function automatic int classify(input logic [5:0] op);
        int v = int'(op);
        if (v == 0)                 return K_NOOP;
        if (v == 1)                 return K_JUMP;
        if (v >= 16 && v <= 31)     return K_R;
        if (v >= 32 && v <= 35)     return K_BR;
        if (v >= 50 && v <= 55)     return K_IMM;
        if (v == 57 || v == 58)     return K_IMM;
        if (v == 59 || v == 61)     return K_LD;
        if (v == 60 || v == 62)     return K_ST;
        return K_ILL;
    endfunction

    task automatic push(input logic mr, input out_t o, input logic rel);
        cyc_t c;
        out_t m;
        m = '1;
        if (rel) begin
            m.mrd = 1'b0;
            m.mwr = 1'b0;
        end
        c.mr   = mr;
        c.exp  = o;
        c.mask = m;
        plan.push_back(c);
    endtask

    // fw/mw: cycles of mem_ready=0 before the access completes; above WAIT_MAX means a timeout.
    task automatic build(input logic [5:0] op, input int fw, input int mw);
        int   k;
        out_t o;
        k = classify(op);
        plan.delete();
        o = '0; o.srcb = 2'd1; o.mrd = 1'b1;
        for (int i = 0; i < fw && i < WAIT_MAX; i++) push(1'b0, o, 1'b0);
        if (fw > WAIT_MAX) begin
            o.berr = 1'b1;
            push(1'b0, o, 1'b1);
            return;
        end
        o.irw = 1'b1; o.pcw = 1'b1;
        push(1'b1, o, 1'b0);

        o = '0; o.st = 3'd1; o.srcb = 2'd3; o.ill = (k == K_ILL);
        push(1'($urandom_range(0, 1)), o, 1'b0);
        if (k == K_NOOP || k == K_ILL) return;

        o = '0; o.st = 3'd2;
        case (k)
            K_JUMP: begin o.pcw = 1'b1; o.pcs = 2'd2; end
            K_BR:   begin o.aluop = 2'd2; o.srca = 1'b1; o.pcwc = 1'b1; o.pcs = 2'd1; end
            K_R:    begin o.aluop = 2'd2; o.srca = 1'b1; end
            K_IMM:  begin o.aluop = 2'd2; o.srca = 1'b1; o.srcb = 2'd2; end
            default: begin o.srca = 1'b1; o.srcb = 2'd2; end
        endcase
        push(1'($urandom_range(0, 1)), o, 1'b0);
        if (k == K_JUMP || k == K_BR) return;

        if (k == K_LD || k == K_ST) begin
            o = '0; o.st = 3'd3; o.iord = 1'b1; o.mrd = (k == K_LD); o.mwr = (k == K_ST);
            for (int i = 0; i < mw && i < WAIT_MAX; i++) push(1'b0, o, 1'b0);
            if (mw > WAIT_MAX) begin
                o.berr = 1'b1;
                push(1'b0, o, 1'b1);
                return;
            end
            push(1'b1, o, 1'b0);
            if (k == K_ST) return;
        end
        o = '0; o.st = 3'd4; o.rw = 1'b1; o.m2r = (k == K_LD);
        push(1'($urandom_range(0, 1)), o, 1'b0);
    endtask

    // Entered and left at posedge+1; outputs are sampled on the falling edge.
    task automatic run_plan(input string name, input int n);
        rw_seen = 0; mwr_seen = 0; ill_seen = 0; berr_seen = 0;
        for (int i = 0; i < n && i < plan.size(); i++) begin
            mem_ready = plan[i].mr;
            @(negedge clk);
            total++;
            if ((20'(act) & plan[i].mask) != (plan[i].exp & plan[i].mask)) begin
                bad++;
                $display("FAIL %s cyc%0d: got %05h want %05h (mask %05h)", name, i,
                         20'(act), plan[i].exp, plan[i].mask);
            end
            rw_seen   += int'(reg_write);
            mwr_seen  += int'(mem_write);
            ill_seen  += int'(illegal_op);
            berr_seen += int'(bus_err);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input int fw,
                             input int mw);
        opcode = op;
        build(op, fw, mw);
        run_plan(name, plan.size());
        total++;
        if (state_dbg != 3'd0) begin
            bad++;
            $display("FAIL %s end_state: got %0d want 0", name, state_dbg);
        end
        $display("instr %-8s op=%06b fw=%0d mw=%0d cycles=%0d rw=%0d mwr=%0d ill=%0d berr=%0d",
                 name, op, fw, mw, plan.size(), rw_seen, mwr_seen, ill_seen, berr_seen);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[15];
        logic [5:0] ill_ops[10];
        logic [5:0] op;
        int fw, mw;

        //        name      op         fw  mw  cyc rw mwr ill berr
        vecs[0]  = '{"add",    6'b010010, 0,  0,  4,  1, 0,  0, 0};
        vecs[1]  = '{"lw_w3",  6'b111101, 0,  3,  8,  1, 0,  0, 0};
        vecs[2]  = '{"beq",    6'b100000, 0,  0,  3,  0, 0,  0, 0};
        vecs[3]  = '{"undef",  6'b001111, 0,  0,  2,  0, 0,  1, 0};
        vecs[4]  = '{"noop",   6'b000000, 0,  0,  2,  0, 0,  0, 0};
        vecs[5]  = '{"j",      6'b000001, 0,  0,  3,  0, 0,  0, 0};
        vecs[6]  = '{"sw",     6'b111110, 0,  0,  4,  0, 1,  0, 0};
        vecs[7]  = '{"imm",    6'b110010, 0,  0,  4,  1, 0,  0, 0};
        vecs[8]  = '{"lw",     6'b111101, 0,  0,  5,  1, 0,  0, 0};
        vecs[9]  = '{"sw_w2",  6'b111110, 0,  2,  6,  0, 3,  0, 0};
        vecs[10] = '{"add_f2", 6'b010010, 2,  0,  6,  1, 0,  0, 0};
        vecs[11] = '{"f_tmo",  6'b010010, 16, 0,  16, 0, 0,  0, 1};
        vecs[12] = '{"f_w15",  6'b010010, 15, 0,  19, 1, 0,  0, 0};
        vecs[13] = '{"lw_tmo", 6'b111101, 0,  16, 19, 0, 0,  0, 1};
        vecs[14] = '{"lw_w15", 6'b111101, 0,  15, 20, 1, 0,  0, 0};

        ill_ops = '{6'd2, 6'd7, 6'd15, 6'd36, 6'd40, 6'd47, 6'd48, 6'd49, 6'd56, 6'd63};

        rst = 1'b1; opcode = 6'b010010; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (20'(act) != 20'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %05h want 00000", 20'(act));
        end
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_instr(vecs[i].name, vecs[i].op, vecs[i].fw, vecs[i].mw);
            check_int({vecs[i].name, "_cycles"}, plan.size(), vecs[i].cycles);
            check_int({vecs[i].name, "_reg_write"}, rw_seen, vecs[i].rw_n);
            check_int({vecs[i].name, "_mem_write"}, mwr_seen, vecs[i].mwr_n);
            check_int({vecs[i].name, "_illegal"}, ill_seen, vecs[i].ill_n);
            check_int({vecs[i].name, "_bus_err"}, berr_seen, vecs[i].berr_n);
        end

        // Store interrupted by reset while waiting in MEM.
        opcode = 6'b111110;
        build(6'b111110, 0, 5);
        run_plan("sw_rst", 5);
        mem_ready = 1'b0;
        #1;
        check_int("sw_rst_pre_mem_write", int'(mem_write), 1);
        #1 rst = 1'b1;
        #1;
        total++;
        if (20'(act) != 20'd0) begin
            bad++;
            $display("FAIL sw_rst_async: got %05h want 00000", 20'(act));
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr("post_rst", 6'b000000, 1, 0);
        check_int("post_rst_mem_write", mwr_seen, 0);
        check_int("post_rst_reg_write", rw_seen, 0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0: op = 6'd0;
                1: op = 6'd1;
                2: op = 6'(16 + $urandom_range(0, 7));
                3: op = 6'(32 + $urandom_range(0, 3));
                4: op = 6'(50 + $urandom_range(0, 5));
                5: op = 6'd61;
                6: op = 6'd62;
                default: op = ill_ops[$urandom_range(0, 9)];
            endcase
            fw = ($urandom_range(0, 14) == 0) ? 16 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(0, 4));
            run_instr("rand", op, fw, mw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
